// File: rtl/ldst_unit.sv
// rtl/ldst_unit.sv - memory-stage load/store unit with req/gnt/rvalid data-memory handshake
module ldst_unit #(
    parameter int DataWidth    = 32,
    parameter int AddrWidth    = 10,
    parameter int RegAddrWidth = 5
) (
    input  logic                    brq_clk,
    input  logic                    brq_rst_n,
    input  logic                    ieu_mem_ren,
    input  logic                    ieu_mem_wen,
    input  logic                    ieu_memtoreg,
    input  logic                    ieu_regfile_en,
    input  logic [2:0]              ieu_func3,
    input  logic [RegAddrWidth-1:0] ieu_addr_dst,
    input  logic [DataWidth-1:0]    ieu_mem_addr,
    input  logic [DataWidth-1:0]    ieu_store_data,
    input  logic [DataWidth-1:0]    ieu_alu_result_dealy,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [3:0]              dmem_be,
    output logic [AddrWidth-1:0]    dmem_addr,
    output logic [DataWidth-1:0]    dmem_wdata,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [DataWidth-1:0]    dmem_rdata,
    output logic                    ldst_stall,
    output logic                    ldst_regfile_en,
    output logic [RegAddrWidth-1:0] ldst_addr_dst,
    output logic [DataWidth-1:0]    ldst_mem_result,
    output logic                    ldst_misaligned,
    output logic [DataWidth-1:0]    ldst_fault_addr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]              state;
    logic [2:0]              held_func3;
    logic [1:0]              held_off;
    logic [RegAddrWidth-1:0] held_rd;
    logic                    held_rf_en;

    logic                    access;
    logic                    is_half;
    logic                    is_word;
    logic                    misaligned;
    logic                    start;
    logic [3:0]              be_next;
    logic [DataWidth-1:0]    wdata_next;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DataWidth-1:0]    load_fmt;

    // Upper address bits fall outside the data memory; memtoreg is implied by ren.
    logic unused_bits;
    assign unused_bits = ^{ieu_memtoreg, ieu_mem_addr[DataWidth-1:AddrWidth+2]};

    // func3[1] set covers LW/SW and the undefined 011/110/111 encodings.
    always_comb begin
        access     = ieu_mem_ren | ieu_mem_wen;
        is_half    = (ieu_func3[1:0] == 2'b01);
        is_word    = ieu_func3[1];
        misaligned = access & ((is_half & ieu_mem_addr[0]) |
                               (is_word & (ieu_mem_addr[1:0] != 2'b00)));
        start      = (state == IDLE) & access & ~misaligned;
    end

    always_comb begin
        if (is_word) begin
            be_next    = 4'b1111;
            wdata_next = ieu_store_data;
        end else if (is_half) begin
            be_next    = ieu_mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{ieu_store_data[15:0]}};
        end else begin
            be_next    = 4'b0001 << ieu_mem_addr[1:0];
            wdata_next = {4{ieu_store_data[7:0]}};
        end
    end

    always_comb begin
        ld_byte = dmem_rdata[{held_off, 3'b000} +: 8];
        ld_half = held_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (held_func3[1]) begin
            load_fmt = dmem_rdata;
        end else if (held_func3[0]) begin
            load_fmt = {{16{ld_half[15] & ~held_func3[2]}}, ld_half};
        end else begin
            load_fmt = {{24{ld_byte[7] & ~held_func3[2]}}, ld_byte};
        end
    end

    assign dmem_req = (state == REQ);

    // A granted store releases the pipeline in its gnt cycle; loads hold until rvalid.
    always_comb begin
        ldst_stall = 1'b0;
        if (brq_rst_n) begin
            case (state)
                IDLE:    ldst_stall = start;
                REQ:     ldst_stall = ~(dmem_gnt & dmem_we);
                WAIT:    ldst_stall = ~dmem_rvalid;
                default: ldst_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge brq_clk) begin
        if (!brq_rst_n) begin
            state           <= IDLE;
            held_func3      <= 3'b000;
            held_off        <= 2'b00;
            held_rd         <= '0;
            held_rf_en      <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_be         <= 4'b0000;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            ldst_regfile_en <= 1'b0;
            ldst_addr_dst   <= '0;
            ldst_mem_result <= '0;
            ldst_misaligned <= 1'b0;
            ldst_fault_addr <= '0;
        end else begin
            ldst_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        held_func3      <= ieu_func3;
                        held_off        <= ieu_mem_addr[1:0];
                        held_rd         <= ieu_addr_dst;
                        held_rf_en      <= ieu_regfile_en;
                        dmem_we         <= ~ieu_mem_ren;
                        dmem_be         <= be_next;
                        dmem_addr       <= ieu_mem_addr[AddrWidth+1:2];
                        dmem_wdata      <= wdata_next;
                        ldst_regfile_en <= 1'b0;
                        state           <= REQ;
                    end else if (misaligned) begin
                        ldst_misaligned <= 1'b1;
                        ldst_fault_addr <= ieu_mem_addr;
                        ldst_regfile_en <= 1'b0;
                    end else begin
                        ldst_mem_result <= ieu_alu_result_dealy;
                        ldst_regfile_en <= ieu_regfile_en;
                        ldst_addr_dst   <= ieu_addr_dst;
                    end
                end
                REQ: begin
                    ldst_regfile_en <= 1'b0;
                    if (dmem_gnt) begin
                        state <= dmem_we ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        ldst_mem_result <= load_fmt;
                        ldst_regfile_en <= held_rf_en;
                        ldst_addr_dst   <= held_rd;
                        state           <= IDLE;
                    end else begin
                        ldst_regfile_en <= 1'b0;
                    end
                end
                default: begin
                    ldst_regfile_en <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldst_unit.sv
// tb/tb_ldst_unit.sv - vector table plus scoreboard bench for ldst_unit
module tb_ldst_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ren, wen, memtoreg, rf_en_in;
    logic [2:0]  func3;
    logic [4:0]  addr_dst;
    logic [31:0] mem_addr, store_data, alu_result;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [3:0]  dmem_be;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        ldst_stall, ldst_regfile_en, ldst_misaligned;
    logic [4:0]  ldst_addr_dst;
    logic [31:0] ldst_mem_result, ldst_fault_addr;

    always #5 clk = ~clk;

    ldst_unit #(.DataWidth(32), .AddrWidth(10), .RegAddrWidth(5)) dut (
        .brq_clk(clk), .brq_rst_n(rst_n),
        .ieu_mem_ren(ren), .ieu_mem_wen(wen), .ieu_memtoreg(memtoreg),
        .ieu_regfile_en(rf_en_in), .ieu_func3(func3), .ieu_addr_dst(addr_dst),
        .ieu_mem_addr(mem_addr), .ieu_store_data(store_data),
        .ieu_alu_result_dealy(alu_result),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .ldst_stall(ldst_stall), .ldst_regfile_en(ldst_regfile_en),
        .ldst_addr_dst(ldst_addr_dst), .ldst_mem_result(ldst_mem_result),
        .ldst_misaligned(ldst_misaligned), .ldst_fault_addr(ldst_fault_addr)
    );

    typedef struct {
        logic        ren, wen;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, mword;
        logic        rf_en;
        logic [4:0]  rd;
        int          gd, rv;
        logic [3:0]  be;
        logic [31:0] wdata, res;
        logic        mis;
    } vec_t;

    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
    typedef struct { logic [9:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; int gd; int rv; } bus_t;

    wb_t         wb_q[$];
    bus_t        bus_q[$];
    logic [31:0] mis_q[$];
    vec_t        vecs[$];

    int tests = 0;
    int fails = 0;

    logic [31:0] mem_word = 32'h0;
    int          gcnt = 0;
    int          rv_cnt = 0;
    bit          rd_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got 0x%08h with nothing expected", name, act);
    endtask

    // Memory responder: gnt after gd wait cycles, rvalid rv cycles after the gnt cycle.
    always begin
        @(posedge clk);
        #2;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (rd_pend) begin
            if (rv_cnt == 0) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = mem_word;
                rd_pend     = 1'b0;
            end else begin
                rv_cnt--;
            end
        end
        if (dmem_req) begin
            if (bus_q.size() == 0) begin
                unexpected("unexpected_req", {22'h0, dmem_addr});
            end else begin
                check("req_addr", {22'h0, dmem_addr}, {22'h0, bus_q[0].addr});
                check("req_we", {31'h0, dmem_we}, {31'h0, bus_q[0].we});
                if (gcnt == bus_q[0].gd) begin
                    dmem_gnt = 1'b1;
                    if (bus_q[0].we) begin
                        check("store_be", {28'h0, dmem_be}, {28'h0, bus_q[0].be});
                        check("store_wdata", dmem_wdata, bus_q[0].wdata);
                    end else begin
                        rd_pend = 1'b1;
                        rv_cnt  = bus_q[0].rv;
                    end
                    gcnt = 0;
                    void'(bus_q.pop_front());
                end else begin
                    gcnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ldst_regfile_en === 1'b1) begin
            if (wb_q.size() == 0) begin
                unexpected("unexpected_wb", ldst_mem_result);
            end else begin
                check("wb_rd", {27'h0, ldst_addr_dst}, {27'h0, wb_q[0].rd});
                check("wb_data", ldst_mem_result, wb_q[0].data);
                void'(wb_q.pop_front());
            end
        end
        if (ldst_misaligned === 1'b1) begin
            if (mis_q.size() == 0) begin
                unexpected("unexpected_misaligned", ldst_fault_addr);
            end else begin
                check("fault_addr", ldst_fault_addr, mis_q[0]);
                void'(mis_q.pop_front());
            end
        end
    end

    task automatic drive_idle();
        ren = 1'b0; wen = 1'b0; memtoreg = 1'b0; rf_en_in = 1'b0; func3 = 3'b000;
        addr_dst = 5'd0; mem_addr = 32'h0; store_data = 32'h0; alu_result = 32'h0;
    endtask

    task automatic issue(input vec_t v, output int stalls);
        bit done;
        ren = v.ren; wen = v.wen; memtoreg = v.ren; rf_en_in = v.rf_en; func3 = v.f3;
        addr_dst = v.rd; mem_addr = v.addr; store_data = v.sdata; alu_result = v.res;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ldst_stall) begin
                stalls++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) unexpected("issue_timeout", v.addr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'h0, dmem_req}, 32'h0);
        check({tag, "_we"}, {31'h0, dmem_we}, 32'h0);
        check({tag, "_be"}, {28'h0, dmem_be}, 32'h0);
        check({tag, "_addr"}, {22'h0, dmem_addr}, 32'h0);
        check({tag, "_wdata"}, dmem_wdata, 32'h0);
        check({tag, "_rf_en"}, {31'h0, ldst_regfile_en}, 32'h0);
        check({tag, "_dst"}, {27'h0, ldst_addr_dst}, 32'h0);
        check({tag, "_result"}, ldst_mem_result, 32'h0);
        check({tag, "_mis"}, {31'h0, ldst_misaligned}, 32'h0);
        check({tag, "_fault"}, ldst_fault_addr, 32'h0);
        check({tag, "_stall"}, {31'h0, ldst_stall}, 32'h0);
    endtask

    initial begin
        int   st;
        int   exp_st;
        vec_t v;
        logic [31:0] mw;
        mw = 32'h80F1_7F02;
        //            ren  wen  f3     addr          sdata          mword rf   rd  gd rv be     wdata          res            mis
        vecs.push_back('{1'b0,1'b0,3'b000,32'h0,       32'h0,         32'h0,1'b1,5'd7,0,0,4'h0,32'h0,         32'h0000_1234,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b010,32'h300,     32'h0,         mw,   1'b1,5'd5,0,0,4'h0,32'h0,         32'h80F1_7F02,1'b0});
        vecs.push_back('{1'b0,1'b0,3'b000,32'h0,       32'h0,         32'h0,1'b1,5'd8,0,0,4'h0,32'h0,         32'h0000_ABCD,1'b0});
        vecs.push_back('{1'b0,1'b1,3'b010,32'h104,     32'hDEADBEEF,  32'h0,1'b1,5'd3,2,0,4'hF,32'hDEADBEEF,  32'h0,        1'b0});
        vecs.push_back('{1'b0,1'b1,3'b000,32'h203,     32'h0000_00A5, 32'h0,1'b0,5'd0,0,0,4'h8,32'hA5A5A5A5,  32'h0,        1'b0});
        vecs.push_back('{1'b0,1'b1,3'b001,32'h202,     32'h1234_BEEF, 32'h0,1'b0,5'd0,1,0,4'hC,32'hBEEFBEEF,  32'h0,        1'b0});
        vecs.push_back('{1'b0,1'b1,3'b000,32'h001,     32'h1122_3344, 32'h0,1'b0,5'd0,0,0,4'h2,32'h44444444,  32'h0,        1'b0});
        vecs.push_back('{1'b0,1'b1,3'b001,32'h000,     32'h0000_CAFE, 32'h0,1'b0,5'd0,0,0,4'h3,32'hCAFECAFE,  32'h0,        1'b0});
        vecs.push_back('{1'b1,1'b0,3'b000,32'h303,     32'h0,         mw,   1'b1,5'd5,0,0,4'h0,32'h0,         32'hFFFF_FF80,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b100,32'h303,     32'h0,         mw,   1'b1,5'd5,1,2,4'h0,32'h0,         32'h0000_0080,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b001,32'h302,     32'h0,         mw,   1'b1,5'd6,0,1,4'h0,32'h0,         32'hFFFF_80F1,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b101,32'h300,     32'h0,         mw,   1'b1,5'd6,0,0,4'h0,32'h0,         32'h0000_7F02,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b000,32'h301,     32'h0,         mw,   1'b1,5'd1,0,0,4'h0,32'h0,         32'h0000_007F,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b000,32'h300,     32'h0,         mw,   1'b1,5'd2,0,0,4'h0,32'h0,         32'h0000_0002,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b001,32'h300,     32'h0,         mw,   1'b1,5'd3,0,0,4'h0,32'h0,         32'h0000_7F02,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b000,32'h302,     32'h0,         mw,   1'b1,5'd4,3,3,4'h0,32'h0,         32'hFFFF_FFF1,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b010,32'h306,     32'h0,         mw,   1'b1,5'd5,0,0,4'h0,32'h0,         32'h0,        1'b1});
        vecs.push_back('{1'b1,1'b0,3'b001,32'h301,     32'h0,         mw,   1'b1,5'd5,0,0,4'h0,32'h0,         32'h0,        1'b1});
        vecs.push_back('{1'b0,1'b1,3'b010,32'h102,     32'h1,         32'h0,1'b0,5'd0,0,0,4'h0,32'h0,         32'h0,        1'b1});
        vecs.push_back('{1'b0,1'b1,3'b001,32'h203,     32'h1,         32'h0,1'b0,5'd0,0,0,4'h0,32'h0,         32'h0,        1'b1});
        vecs.push_back('{1'b1,1'b0,3'b011,32'h300,     32'h0,         mw,   1'b1,5'd10,0,0,4'h0,32'h0,        32'h80F1_7F02,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b110,32'h300,     32'h0,         mw,   1'b1,5'd11,1,1,4'h0,32'h0,        32'h80F1_7F02,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b111,32'h302,     32'h0,         mw,   1'b1,5'd12,0,0,4'h0,32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1,1'b1,3'b010,32'h300,     32'h5555_5555, mw,   1'b1,5'd9,0,0,4'h0,32'h0,         32'h80F1_7F02,1'b0});
        vecs.push_back('{1'b1,1'b0,3'b010,32'h300,     32'h0,         mw,   1'b0,5'd9,0,0,4'h0,32'h0,         32'h80F1_7F02,1'b0});
        vecs.push_back('{1'b0,1'b0,3'b000,32'h0,       32'h0,         32'h0,1'b0,5'd13,0,0,4'h0,32'h0,        32'h0000_9999,1'b0});
        vecs.push_back('{1'b0,1'b0,3'b000,32'h0,       32'h0,         32'h0,1'b1,5'd14,0,0,4'h0,32'h0,        32'h0000_5678,1'b0});

        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        drive_idle();
        rst_n = 1'b0;
        ren = 1'b1; func3 = 3'b010; mem_addr = 32'h300;
        @(negedge clk);
        check("stall_in_reset", {31'h0, ldst_stall}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        drive_idle();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            if (v.mis) mis_q.push_back(v.addr);
            else if (v.ren || v.wen) bus_q.push_back('{v.addr[11:2], ~v.ren, v.be, v.wdata, v.gd, v.rv});
            if (!v.mis && v.rf_en && (v.ren || !v.wen)) wb_q.push_back('{v.rd, v.res});
            mem_word = v.mword;
            issue(v, st);
            if (v.mis || !(v.ren || v.wen)) exp_st = 0;
            else if (v.ren) exp_st = 2 + v.gd + v.rv;
            else exp_st = 1 + v.gd;
            check($sformatf("stall_cycles_%0d", i), st, exp_st);
        end
        drive_idle();
        repeat (4) @(posedge clk);
        #1;
        check("wb_q_drained", wb_q.size(), 0);
        check("bus_q_drained", bus_q.size(), 0);
        check("mis_q_drained", mis_q.size(), 0);

        // Reset while a load waits for rvalid; the late rvalid must be ignored.
        mem_word = mw;
        bus_q.push_back('{10'h0C0, 1'b0, 4'hF, 32'h0, 0, 3});
        ren = 1'b1; memtoreg = 1'b1; rf_en_in = 1'b1; func3 = 3'b010; addr_dst = 5'd9; mem_addr = 32'h300;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        check("stall_reset_in_wait", {31'h0, ldst_stall}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (6) @(posedge clk);
        #1;
        check("midreset_bus_q", bus_q.size(), 0);
        check("midreset_wb_q", wb_q.size(), 0);

        v = vecs[1];
        bus_q.push_back('{v.addr[11:2], 1'b0, 4'hF, 32'h0, 0, 0});
        wb_q.push_back('{v.rd, v.res});
        issue(v, st);
        check("recover_stall", st, 2);
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check("recover_wb_q", wb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
